// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// One shift-and-correct step per clock, start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] sreg;
  logic [SW-1:0] step;
  logic [CW-1:0] cnt;
  logic          bad;

  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // Shift right, then pull every digit field >= 8 back by 3.
  always_comb begin
    step = sreg >> 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (step[BIN_W+4*k +: 4] >= 4'd8) begin
        step[BIN_W+4*k +: 4] = step[BIN_W+4*k +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      bin   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              bin   <= '0;
              busy  <= 1'b0;
            end else begin
              sreg  <= {bcd, {BIN_W{1'b0}}};
              cnt   <= '0;
              state <= CONV;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CONV: begin
          sreg <= step;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bin   <= step[BIN_W-1:0];
            err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: directed cases, full 000..999 sweep,
// invalid-digit sampling and random operands against an integer model.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Integer reference: decimal weight per digit, err on any digit > 9.
  function automatic void model(input logic [11:0] v,
                                output int value, output bit bad);
    int w;
    int d;
    value = 0;
    bad   = 1'b0;
    w     = 1;
    for (int k = 0; k < 3; k++) begin
      d = int'((v >> (4 * k)) & 12'hF);
      if (d > 9) bad = 1'b1;
      value += d * w;
      w *= 10;
    end
    if (bad) value = 0;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    r[11:8] = 4'((n / 100) % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  // Called just after a negedge; returns at the negedge of the DONE cycle.
  task automatic run(input logic [11:0] v, input bit mid_en,
                     input logic [11:0] mid_v, input int gap);
    int  got;
    int  busy_n;
    int  exp_v;
    bit  exp_e;
    int  lat;
    model(v, exp_v, exp_e);
    start = 1'b1;
    bcd   = v;
    @(posedge clk);
    got    = 0;
    busy_n = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 2) bcd = 12'($urandom);
      if (mid_en && n == 4) begin
        start = 1'b1;
        bcd   = mid_v;
      end
      if (mid_en && n == 5) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        got = n;
        break;
      end
    end
    lat = exp_e ? 1 : 11;
    check($sformatf("latency %03h", v), got, lat);
    check($sformatf("busy_cycles %03h", v), busy_n, exp_e ? 0 : 10);
    check($sformatf("bin %03h", v), int'(bin), exp_v);
    check($sformatf("err %03h", v), int'(err), int'(exp_e));
    if (gap > 0) begin
      repeat (gap) @(negedge clk);
      check($sformatf("bin_hold %03h", v), int'(bin), exp_v);
      check($sformatf("done_low %03h", v), int'(done), 0);
    end
  endtask

  initial begin
    logic [11:0] v;
    int          pos;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(negedge clk);
    check("rst_bin", int'(bin), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(12'h255, 1'b0, 12'h0, 3);
    run(12'h000, 1'b0, 12'h0, 1);
    run(12'h999, 1'b0, 12'h0, 1);
    run(12'h1A3, 1'b0, 12'h0, 1);
    run(12'h042, 1'b0, 12'h0, 1);
    run(12'h321, 1'b1, 12'h876, 1);
    // Back-to-back: second start lands in the DONE cycle.
    run(12'h617, 1'b0, 12'h0, 0);
    run(12'h100, 1'b0, 12'h0, 1);

    // Reset during iteration 5 abandons the conversion.
    start = 1'b1;
    bcd   = 12'h500;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_bin", int'(bin), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("midrst_quiet", seen, 0);
    end
    run(12'h500, 1'b0, 12'h0, 1);

    for (int i = 0; i < 1000; i++) run(to_bcd(i), 1'b0, 12'h0, 0);

    for (int p = 0; p < 3; p++) begin
      for (int d = 10; d < 16; d++) begin
        v   = to_bcd(int'($urandom_range(0, 999)));
        pos = 4 * p;
        v[pos +: 4] = 4'(d);
        run(v, 1'b0, 12'h0, 0);
      end
    end

    for (int i = 0; i < 40; i++) begin
      v = 12'($urandom);
      run(v, ($urandom_range(0, 1) == 1), 12'($urandom), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
